// File: rtl/dpwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpwm_pkg : shared DPWM types and constants  | rev 1.0              |
// +--------------------------------------------------------------------+
package dpwm_pkg;

  localparam int DPWM_RES = 12;
  localparam int FS_MIN   = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : dpwm_pkg
`default_nettype wire

// File: rtl/dpwm_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpwm_core_if : settings in, gate drives out  | rev 1.0             |
// +--------------------------------------------------------------------+
interface dpwm_core_if #(
  parameter int RESOLUTION = 12
) ();

  logic                  en;
  logic [RESOLUTION-1:0] dc;
  logic [RESOLUTION-1:0] fs;
  logic [RESOLUTION-1:0] dt1;
  logic [RESOLUTION-1:0] dt2;
  logic                  hs;
  logic                  ls;
  logic                  period_start;
  logic [RESOLUTION-1:0] cnt;

  modport master (
    output en, dc, fs, dt1, dt2,
    input  hs, ls, period_start, cnt
  );

  modport slave (
    input  en, dc, fs, dt1, dt2,
    output hs, ls, period_start, cnt
  );

endinterface : dpwm_core_if
`default_nettype wire

// File: rtl/dpwm_window_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpwm_window_cmp : half-open window test lo <= x < hi  | rev 1.0    |
// +--------------------------------------------------------------------+
module dpwm_window_cmp #(
  parameter int WIDTH = 13
) (
  input  wire logic [WIDTH-1:0] x_i,
  input  wire logic [WIDTH-1:0] lo_i,
  input  wire logic [WIDTH-1:0] hi_i,
  output logic                  in_o
);

  assign in_o = (x_i >= lo_i) && (x_i < hi_i);

endmodule : dpwm_window_cmp
`default_nettype wire

// File: rtl/dpwm_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpwm_core : counter PWM, shadowed settings, deadtime  | rev 1.0    |
// +--------------------------------------------------------------------+
module dpwm_core
  import dpwm_pkg::*;
#(
  parameter int RESOLUTION = DPWM_RES
) (
  input  wire logic    clk,
  input  wire logic    rst,
  dpwm_core_if.slave   bus
);

  localparam int W  = RESOLUTION;
  localparam int WX = RESOLUTION + 1;
  localparam logic [W-1:0] c_fs_min = W'(FS_MIN);

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   sh_dc_q, sh_fs_q, sh_dt1_q, sh_dt2_q;
  logic           hs_q, hs_d;
  logic           ls_q, ls_d;
  logic           ps_q, ps_d;
  logic           load_sh;

  logic [W-1:0]   w_fs_eff;
  logic           w_wrap;
  logic [WX-1:0]  w_ls_lo;
  logic           w_hs_win;
  logic           w_ls_win;

  // Unsanitized periods below the minimum run as the minimum so the counter always wraps.
  assign w_fs_eff = (sh_fs_q < c_fs_min) ? c_fs_min : sh_fs_q;
  assign w_wrap   = (cnt_q >= (w_fs_eff - 1'b1));
  assign w_ls_lo  = {1'b0, sh_dc_q} + {1'b0, sh_dt2_q};

  dpwm_window_cmp #(.WIDTH(WX)) u_hs_win (
    .x_i  ({1'b0, cnt_q}),
    .lo_i ({1'b0, sh_dt1_q}),
    .hi_i ({1'b0, sh_dc_q}),
    .in_o (w_hs_win)
  );

  dpwm_window_cmp #(.WIDTH(WX)) u_ls_win (
    .x_i  ({1'b0, cnt_q}),
    .lo_i (w_ls_lo),
    .hi_i ({1'b0, w_fs_eff}),
    .in_o (w_ls_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_sh = 1'b0;
    hs_d    = 1'b0;
    ls_d    = 1'b0;
    ps_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = ST_RUN;
          load_sh = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          // High side wins any computed overlap, so the gates can never both conduct.
          hs_d = w_hs_win;
          ls_d = w_ls_win & ~w_hs_win;
          ps_d = (cnt_q == '0);
          if (w_wrap) begin
            cnt_d   = '0;
            load_sh = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      sh_dc_q  <= '0;
      sh_fs_q  <= '0;
      sh_dt1_q <= '0;
      sh_dt2_q <= '0;
      hs_q     <= 1'b0;
      ls_q     <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hs_q  <= hs_d;
      ls_q  <= ls_d;
      ps_q  <= ps_d;
      if (load_sh) begin
        sh_dc_q  <= bus.dc;
        sh_fs_q  <= bus.fs;
        sh_dt1_q <= bus.dt1;
        sh_dt2_q <= bus.dt2;
      end
    end
  end

  assign bus.hs           = hs_q;
  assign bus.ls           = ls_q;
  assign bus.period_start = ps_q;
  assign bus.cnt          = cnt_q;

endmodule : dpwm_core
`default_nettype wire

// File: tb/tb_dpwm_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dpwm_core : directed self-checking bench for dpwm_core | rev 1.0|
// +--------------------------------------------------------------------+
module tb_dpwm_core;

  localparam int RES = 12;

  logic clk;
  logic rst;

  dpwm_core_if #(.RESOLUTION(RES)) bus ();

  dpwm_core #(.RESOLUTION(RES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic           hs_log [0:255];
  logic           ls_log [0:255];
  logic           ps_log [0:255];
  logic [RES-1:0] cnt_log[0:255];

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leave RUN, load new settings, and re-enter RUN; afterwards cnt=0.
  task automatic restart(input int dc_v, input int fs_v, input int dt1_v, input int dt2_v);
    bus.en = 1'b0;
    tick();
    bus.dc  = RES'(dc_v);
    bus.fs  = RES'(fs_v);
    bus.dt1 = RES'(dt1_v);
    bus.dt2 = RES'(dt2_v);
    bus.en  = 1'b1;
    tick();
  endtask

  task automatic run_log(input int n, input int chg_at, input int chg_dc);
    for (int k = 1; k <= n; k++) begin
      tick();
      hs_log[k]  = bus.hs;
      ls_log[k]  = bus.ls;
      ps_log[k]  = bus.period_start;
      cnt_log[k] = bus.cnt;
      if (k == chg_at) bus.dc = RES'(chg_dc);
    end
  endtask

  function automatic logic sel_log(input int sel, input int k);
    case (sel)
      0:       return hs_log[k];
      1:       return ls_log[k];
      default: return ps_log[k];
    endcase
  endfunction

  function automatic int count_hi(input int sel, input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) if (sel_log(sel, k)) s++;
    return s;
  endfunction

  function automatic int first_at(input int sel, input int from, input logic val);
    for (int k = from; k <= 255; k++) if (sel_log(sel, k) == val) return k;
    return -1;
  endfunction

  initial begin
    int hr, hf, lr, lf, hr2, p1, p2;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.dc  = '0;
    bus.fs  = '0;
    bus.dt1 = '0;
    bus.dt2 = '0;
    tick();
    chk("reset_hs", bus.hs, 0);
    chk("reset_ls", bus.ls, 0);
    chk("reset_ps", bus.period_start, 0);
    chk("reset_cnt", bus.cnt, 0);
    rst = 1'b0;
    tick();
    chk("idle_cnt", bus.cnt, 0);

    // Nominal 100-cycle period
    restart(40, 100, 5, 10);
    chk("start_cnt", bus.cnt, 0);
    chk("start_ps", bus.period_start, 0);
    run_log(200, 0, 0);
    chk("nom_cnt20", cnt_log[20], 20);
    chk("nom_cnt100", cnt_log[100], 0);
    chk("nom_hs_cnt", count_hi(0, 1, 100), 35);
    chk("nom_ls_cnt", count_hi(1, 1, 100), 50);
    chk("nom_ps_cnt", count_hi(2, 1, 100), 1);
    hr  = first_at(0, 1, 1'b1);
    hf  = first_at(0, hr, 1'b0);
    lr  = first_at(1, hf, 1'b1);
    lf  = first_at(1, lr, 1'b0);
    hr2 = first_at(0, lf, 1'b1);
    p1  = first_at(2, 1, 1'b1);
    p2  = first_at(2, p1 + 1, 1'b1);
    chk("nom_hs_rise", hr, 6);
    chk("nom_hs_width", hf - hr, 35);
    chk("nom_gap_hs_ls", lr - hf, 10);
    chk("nom_ls_width", lf - lr, 50);
    chk("nom_gap_ls_hs", hr2 - lf, 5);
    chk("nom_ps_first", p1, 1);
    chk("nom_ps_period", p2 - p1, 100);

    // dc changes 40->70 at cnt=20: applies only after the wrap
    restart(40, 100, 5, 10);
    run_log(200, 20, 70);
    chk("shd_hs_cur", count_hi(0, 1, 100), 35);
    chk("shd_ls_cur", count_hi(1, 1, 100), 50);
    chk("shd_hs_next", count_hi(0, 101, 200), 65);
    chk("shd_ls_next", count_hi(1, 101, 200), 20);

    restart(0, 2, 0, 0);
    run_log(10, 0, 0);
    chk("fs2_hs", count_hi(0, 1, 10), 0);
    chk("fs2_ls", count_hi(1, 1, 10), 10);
    chk("fs2_ps", count_hi(2, 1, 10), 5);

    restart(40, 100, 5, 60);
    run_log(100, 0, 0);
    chk("dt2max_ls", count_hi(1, 1, 100), 0);
    chk("dt2max_hs", count_hi(0, 1, 100), 35);

    restart(40, 100, 40, 10);
    run_log(100, 0, 0);
    chk("dt1eqdc_hs", count_hi(0, 1, 100), 0);
    chk("dt1eqdc_ls", count_hi(1, 1, 100), 50);

    // Sub-minimum period behaves as period 2
    restart(0, 0, 0, 0);
    run_log(4, 0, 0);
    chk("fs0_cnt1", cnt_log[1], 1);
    chk("fs0_cnt2", cnt_log[2], 0);
    chk("fs0_ls", count_hi(1, 1, 4), 4);

    // Abort mid-period, then re-enable
    restart(40, 100, 5, 10);
    repeat (30) tick();
    chk("abort_pre_cnt", bus.cnt, 30);
    chk("abort_pre_hs", bus.hs, 1);
    bus.en = 1'b0;
    tick();
    chk("abort_hs", bus.hs, 0);
    chk("abort_ls", bus.ls, 0);
    chk("abort_cnt", bus.cnt, 0);
    chk("abort_ps", bus.period_start, 0);
    bus.en = 1'b1;
    tick();
    chk("reen_cnt", bus.cnt, 0);
    tick();
    chk("reen_ps", bus.period_start, 1);
    chk("reen_cnt1", bus.cnt, 1);

    // Asynchronous reset mid-run clears outputs before the next edge
    restart(40, 100, 5, 10);
    repeat (20) tick();
    chk("arst_pre_hs", bus.hs, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hs", bus.hs, 0);
    chk("arst_ls", bus.ls, 0);
    chk("arst_cnt", bus.cnt, 0);
    chk("arst_ps", bus.period_start, 0);
    rst = 1'b0;
    tick();
    chk("arst_restart_cnt", bus.cnt, 0);
    tick();
    chk("arst_restart_ps", bus.period_start, 1);

    // Random unsanitized settings: gates must never overlap
    for (int i = 0; i < 5000; i++) begin
      bus.dc  = RES'($urandom_range(0, 63));
      bus.fs  = RES'($urandom_range(0, 63));
      bus.dt1 = RES'($urandom_range(0, 63));
      bus.dt2 = RES'($urandom_range(0, 63));
      bus.en  = ($urandom_range(0, 31) != 0);
      tick();
      chk("no_overlap", bus.hs & bus.ls, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_dpwm_core
`default_nettype wire
